vga_text_renderer: RTL and testbench



---
 rtl/vga_text_renderer.sv | 138 +++++++++++++
 tb/tb_vga_text_renderer.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/vga_text_renderer.sv
// 80x30 text-mode pixel generator: char RAM -> font ROM -> palette, 3-cycle pipeline.
// Optional blinking underline cursor is enabled by defining VGA_TEXT_CURSOR_EN.
module vga_text_renderer #(
    parameter int COLS      = 80,
    parameter int ROWS      = 30,
    parameter int BLINK_BIT = 4
) (
    input  logic        clock25Mhz,
    input  logic        reset,
    input  logic [9:0]  x,
    input  logic [8:0]  y,
    input  logic        isActive,
    input  logic        hSyncIn,
    input  logic        vSyncIn,
    output logic [11:0] charAddr,
    input  logic [15:0] charData,
    output logic [11:0] fontAddr,
    input  logic [7:0]  fontData,
`ifdef VGA_TEXT_CURSOR_EN
    input  logic [6:0]  cursorCol,
    input  logic [4:0]  cursorRow,
`endif
    output logic [3:0]  red,
    output logic [3:0]  green,
    output logic [3:0]  blue,
    output logic        hSync,
    output logic        vSync
);

    function automatic logic [3:0] chan(input logic on, input logic intens);
        return on ? (intens ? 4'hF : 4'hA) : (intens ? 4'h5 : 4'h0);
    endfunction

    // idx[3] = intensity, idx[2:0] = R,G,B; index 6 is dimmed to brown
    function automatic logic [11:0] palette(input logic [3:0] idx);
        logic [3:0] g;
        g = (idx == 4'd6) ? 4'h5 : chan(idx[1], idx[3]);
        return {chan(idx[2], idx[3]), g, chan(idx[0], idx[3])};
    endfunction

    logic [11:0] char_addr_d, char_addr_q;
    logic        vld_p0_d, vld_p0_q, hs_p0_d, hs_p0_q, vs_p0_d, vs_p0_q;
    logic [3:0]  glyph_p0_d, glyph_p0_q;
    logic [2:0]  bit_p0_d, bit_p0_q;
    logic [4:0]  row_p0_d, row_p0_q;
    logic [11:0] font_addr_d, font_addr_q;
    logic        vld_p1_d, vld_p1_q, hs_p1_d, hs_p1_q, vs_p1_d, vs_p1_q;
    logic [3:0]  fg_p1_d, fg_p1_q, bg_p1_d, bg_p1_q;
    logic        blink_p1_d, blink_p1_q;
    logic [2:0]  bit_p1_d, bit_p1_q;
    logic [4:0]  row_p1_d, row_p1_q;
`ifdef VGA_TEXT_CURSOR_EN
    logic [6:0]  col_p0_d, col_p0_q, col_p1_d, col_p1_q;
    logic [3:0]  glyph_p1_d, glyph_p1_q;
`endif
    logic [11:0] rgb_p2_d, rgb_p2_q;
    logic        hs_p2_d, hs_p2_q, vs_p2_d, vs_p2_q;
    logic [7:0]  frame_cnt_d, frame_cnt_q;
    logic        pix_on;
    logic [3:0]  colour;

    always_comb begin
        // S0: split coordinates into cell/glyph position and address the char RAM
        char_addr_d = 12'(int'(y[8:4]) * COLS + int'(x[9:3]));
        vld_p0_d    = isActive;
        hs_p0_d     = hSyncIn;
        vs_p0_d     = vSyncIn;
        glyph_p0_d  = y[3:0];
        bit_p0_d    = x[2:0];
        row_p0_d    = y[8:4];
`ifdef VGA_TEXT_CURSOR_EN
        col_p0_d    = x[9:3];
        col_p1_d    = col_p0_q;
        glyph_p1_d  = glyph_p0_q;
`endif
        // S1: char word arrives; address the font ROM and keep the attributes
        font_addr_d = {charData[7:0], glyph_p0_q};
        fg_p1_d     = charData[11:8];
        bg_p1_d     = charData[15:12];
        blink_p1_d  = charData[15] && (charData[11:8] != charData[15:12]);
        vld_p1_d    = vld_p0_q;
        hs_p1_d     = hs_p0_q;
        vs_p1_d     = vs_p0_q;
        bit_p1_d    = bit_p0_q;
        row_p1_d    = row_p0_q;
        // S2: glyph row arrives; pick the pixel, apply cursor/blink, map to RGB
        pix_on = fontData[3'd7 - bit_p1_q];
`ifdef VGA_TEXT_CURSOR_EN
        if (col_p1_q == cursorCol && row_p1_q == cursorRow &&
            glyph_p1_q[3:1] == 3'b111 && !frame_cnt_q[BLINK_BIT])
            pix_on = ~pix_on;
`endif
        colour = pix_on ? fg_p1_q : bg_p1_q;
        if (blink_p1_q && frame_cnt_q[BLINK_BIT])
            colour = bg_p1_q;
        rgb_p2_d = palette(colour);
        if (!vld_p1_q || int'(row_p1_q) >= ROWS)
            rgb_p2_d = 12'h000;
        hs_p2_d = hs_p1_q;
        vs_p2_d = vs_p1_q;
        frame_cnt_d = frame_cnt_q;
        if (vs_p2_q && !vs_p1_q)
            frame_cnt_d = frame_cnt_q + 8'd1;
    end

    always_ff @(posedge clock25Mhz or posedge reset) begin
        if (reset) begin
            char_addr_q <= '0; vld_p0_q <= 1'b0; hs_p0_q <= 1'b0; vs_p0_q <= 1'b0;
            glyph_p0_q  <= '0; bit_p0_q <= '0;   row_p0_q <= '0;
            font_addr_q <= '0; vld_p1_q <= 1'b0; hs_p1_q <= 1'b0; vs_p1_q <= 1'b0;
            fg_p1_q     <= '0; bg_p1_q  <= '0;   blink_p1_q <= 1'b0;
            bit_p1_q    <= '0; row_p1_q <= '0;
`ifdef VGA_TEXT_CURSOR_EN
            col_p0_q <= '0; col_p1_q <= '0; glyph_p1_q <= '0;
`endif
            rgb_p2_q <= '0; hs_p2_q <= 1'b0; vs_p2_q <= 1'b0; frame_cnt_q <= '0;
        end else begin
            char_addr_q <= char_addr_d; vld_p0_q <= vld_p0_d; hs_p0_q <= hs_p0_d; vs_p0_q <= vs_p0_d;
            glyph_p0_q  <= glyph_p0_d;  bit_p0_q <= bit_p0_d; row_p0_q <= row_p0_d;
            font_addr_q <= font_addr_d; vld_p1_q <= vld_p1_d; hs_p1_q <= hs_p1_d; vs_p1_q <= vs_p1_d;
            fg_p1_q     <= fg_p1_d;     bg_p1_q  <= bg_p1_d;  blink_p1_q <= blink_p1_d;
            bit_p1_q    <= bit_p1_d;    row_p1_q <= row_p1_d;
`ifdef VGA_TEXT_CURSOR_EN
            col_p0_q <= col_p0_d; col_p1_q <= col_p1_d; glyph_p1_q <= glyph_p1_d;
`endif
            rgb_p2_q <= rgb_p2_d; hs_p2_q <= hs_p2_d; vs_p2_q <= vs_p2_d; frame_cnt_q <= frame_cnt_d;
        end
    end

    assign charAddr = char_addr_q;
    assign fontAddr = font_addr_q;
    assign red      = rgb_p2_q[11:8];
    assign green    = rgb_p2_q[7:4];
    assign blue     = rgb_p2_q[3:0];
    assign hSync    = hs_p2_q;
    assign vSync    = vs_p2_q;

endmodule

// File: tb/tb_vga_text_renderer.sv
// Bench for vga_text_renderer: RAM/ROM models plus a pixel-level reference of the text screen.
module tb_vga_text_renderer;

    logic        clock25Mhz = 1'b0;
    logic        reset;
    logic [9:0]  x;
    logic [8:0]  y;
    logic        isActive, hSyncIn, vSyncIn;
    logic [11:0] charAddr, fontAddr;
    logic [15:0] charData;
    logic [7:0]  fontData;
    logic [3:0]  red, green, blue;
    logic        hSync, vSync;
`ifdef VGA_TEXT_CURSOR_EN
    logic [6:0]  cursorCol = 7'd5;
    logic [4:0]  cursorRow = 5'd2;
`endif

    always #20 clock25Mhz = ~clock25Mhz;

    logic [15:0] ram  [0:4095];
    logic [7:0]  font [0:4095];
    assign charData = ram[charAddr];
    assign fontData = font[fontAddr];

    vga_text_renderer dut (
        .clock25Mhz(clock25Mhz), .reset(reset), .x(x), .y(y), .isActive(isActive),
        .hSyncIn(hSyncIn), .vSyncIn(vSyncIn), .charAddr(charAddr), .charData(charData),
        .fontAddr(fontAddr), .fontData(fontData),
`ifdef VGA_TEXT_CURSOR_EN
        .cursorCol(cursorCol), .cursorRow(cursorRow),
`endif
        .red(red), .green(green), .blue(blue), .hSync(hSync), .vSync(vSync));

    typedef struct packed {
        logic        act, hs, vs;
        logic [11:0] addr, faddr;
        logic [3:0]  fg, bg;
        logic        blink, pix, cur;
        logic [4:0]  row;
    } ent_t;

    ent_t        q[$];
    logic [11:0] rgb_log[$];
    int          tests = 0, fails = 0;
    logic [7:0]  fc_m;
    logic        prev_vs;

    // What the screen should show for one input pixel, frame-independent part
    function automatic ent_t mk(int px, int py, logic a, logic h, logic v);
        ent_t e;
        int col, row, gr, bs;
        logic [15:0] w;
        logic [7:0]  g;
        col = px / 8; row = py / 16; gr = py % 16; bs = px % 8;
        e.addr  = 12'((row * 80 + col) % 4096);
        w       = ram[e.addr];
        e.faddr = 12'(w[7:0] * 16 + gr);
        e.fg    = w[11:8];
        e.bg    = w[15:12];
        e.blink = w[15] && (e.fg != e.bg);
        g       = font[e.faddr];
        e.pix   = g[7 - bs];
        e.cur   = (col == 5) && (row == 2) && (gr >= 14);
        e.row   = 5'(row);
        e.act = a; e.hs = h; e.vs = v;
        return e;
    endfunction

    function automatic logic [3:0] level(logic [3:0] idx, int ch);
        int v;
        v = 10 * int'(idx[ch]) + 5 * int'(idx[3]);
        if (idx == 4'd6 && ch == 1) v = 5;
        return 4'(v);
    endfunction

    function automatic logic [11:0] exp_rgb(ent_t e, logic [7:0] fc);
        logic on;
        logic [3:0] idx;
        if (!e.act || e.row >= 5'd30) return 12'h000;
        on = e.pix;
`ifdef VGA_TEXT_CURSOR_EN
        if (e.cur && !fc[4]) on = ~on;
`endif
        idx = on ? e.fg : e.bg;
        if (e.blink && fc[4]) idx = e.bg;
        return {level(idx, 2), level(idx, 1), level(idx, 0)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // One pixel clock: check everything the DUT shows, then apply the next input
    task automatic cyc(input int nx, input int ny, input logic na, input logic nh, input logic nv);
        ent_t e;
        @(posedge clock25Mhz); #1;
        chk("charAddr", 32'(charAddr), 32'(q[2].addr));
        chk("fontAddr", 32'(fontAddr), 32'(q[1].faddr));
        e = q.pop_front();
        chk("rgb", 32'({red, green, blue}), 32'(exp_rgb(e, fc_m)));
        chk("hSync", 32'(hSync), 32'(e.hs));
        chk("vSync", 32'(vSync), 32'(e.vs));
        rgb_log.push_back({red, green, blue});
        if (prev_vs && !e.vs) fc_m = fc_m + 8'd1;
        prev_vs = e.vs;
        x = 10'(nx); y = 9'(ny); isActive = na; hSyncIn = nh; vSyncIn = nv;
        q.push_back(mk(nx, ny, na, nh, nv));
    endtask

    task automatic do_reset();
        @(negedge clock25Mhz);
        #3 reset = 1'b1;
        x = '0; y = '0; isActive = 1'b0; hSyncIn = 1'b0; vSyncIn = 1'b0;
        #1;
        chk("rst_charAddr", 32'(charAddr), 0);
        chk("rst_fontAddr", 32'(fontAddr), 0);
        chk("rst_rgb", 32'({red, green, blue}), 0);
        chk("rst_syncs", 32'({hSync, vSync}), 0);
        repeat (2) @(negedge clock25Mhz);
        reset = 1'b0;
        fc_m = '0; prev_vs = 1'b0;
        q.delete();
        repeat (3) q.push_back(mk(0, 0, 1'b0, 1'b0, 1'b0));
    endtask

    initial begin
        reset = 1'b1; x = '0; y = '0; isActive = 1'b0; hSyncIn = 1'b0; vSyncIn = 1'b0;
        for (int i = 0; i < 4096; i++) begin
            ram[i]  = 16'($urandom);
            font[i] = 8'($urandom);
        end
        ram[0]      = 16'h1F41;
        ram[2]      = 16'h9C41;
        font[12'h410] = 8'h80;
        do_reset();

        // First cell: 'A' white on blue, pixel 0 lit, pixel 1 background
        rgb_log.delete();
        for (int i = 0; i < 8; i++) cyc(i, 0, 1'b1, 1'b1, 1'b1);
        chk("tp_pix0", 32'(rgb_log[3]), 32'h0FFF);
        chk("tp_pix1", 32'(rgb_log[4]), 32'h000A);

        // Second text row: cell address 81
        for (int i = 8; i < 16; i++) cyc(i, 16, 1'b1, 1'b1, 1'b1);

        // 96-cycle hSync pulse, then blanked area with live attributes
        for (int i = 0; i < 96; i++) cyc(640 + i, 20, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) cyc(i, 16, 1'b0, 1'b1, 1'b1);

        // Many short frames so blink and cursor phases both occur and the counter wraps
        for (int f = 0; f < 300; f++) begin
            for (int i = 0; i < 8; i++) cyc(16 + i, 0, 1'b1, 1'b1, 1'b1);
            for (int i = 0; i < 8; i++) cyc(40 + i, 46, 1'b1, 1'b1, 1'b0);
        end

        // Random sweep, including rows >= 30 and off-screen coordinates
        for (int i = 0; i < 2500; i++)
            cyc($urandom_range(0, 1023), $urandom_range(0, 511), 1'($urandom_range(0, 3) != 0),
                1'($urandom), 1'($urandom_range(0, 7) != 0));

        // Reset in the middle of a line, then recover
        for (int i = 0; i < 5; i++) cyc(i, 0, 1'b1, 1'b1, 1'b1);
        do_reset();
        for (int i = 0; i < 1000; i++)
            cyc($urandom_range(0, 1023), $urandom_range(0, 511), 1'($urandom),
                1'($urandom), 1'($urandom_range(0, 3) != 0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
